// File: rtl/rx_filt_pkg.sv
// Shared types and width helpers for the receive FIR filter.
// Holds the control FSM state encoding and default parameter constants.
package rx_filt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_NTAPS     = 65;
    localparam int DEF_OUT_SHIFT = 14;

    // Accumulator width that cannot wrap over a full filter pass.
    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // One guard bit so adding the rounding constant cannot overflow.
    function automatic int rnd_width(input int acc_w);
        return acc_w + 1;
    endfunction

    function automatic int idx_width(input int ntaps);
        return (ntaps <= 2) ? 1 : $clog2(ntaps);
    endfunction

endpackage

// File: rtl/rx_mac_slice.sv
// Registered signed multiply-accumulate used by the time-multiplexed FIR.
// Reset has priority over clear, clear over enable.
module rx_mac_slice
    import rx_filt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DATA_W + COEF_W + 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc_p0;

    assign prod = PW'(x) * PW'(h);

    // p0: accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0 <= '0;
        end else if (clear) begin
            acc_p0 <= '0;
        end else if (enable) begin
            acc_p0 <= acc_p0 + ACC_W'(prod);
        end
    end

    assign acc = acc_p0;

endmodule

// File: rtl/rx_fir_mac.sv
// Time-multiplexed receive FIR: one multiply-accumulate per cycle over NTAPS taps,
// followed by round-half-up, arithmetic shift and saturation to DATA_W.
module rx_fir_mac
    import rx_filt_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int NTAPS     = DEF_NTAPS,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int ACC_W     = acc_width(DATA_W, COEF_W, NTAPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_wr,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data
);

    localparam int AW       = $clog2(NTAPS);
    localparam int RW       = rnd_width(ACC_W);
    localparam int HALF_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic signed [RW-1:0]     RND_HALF = (OUT_SHIFT > 0) ? (RW'(1) << HALF_POS) : '0;
    localparam logic signed [RW-1:0]     SAT_MAX  = RW'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [RW-1:0]     SAT_MIN  = ~SAT_MAX;
    localparam logic signed [COEF_W-1:0] H_ONE    = COEF_W'(1) << OUT_SHIFT;

    fir_state_t state, state_nx;

    logic [AW-1:0]            tap_idx;
    logic                     flush;
    logic                     last_tap;
    logic                     accept;
    logic                     coef_we;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;

    logic signed [DATA_W-1:0] x_line [NTAPS];
    logic signed [COEF_W-1:0] h_ram  [NTAPS];

    function automatic logic signed [RW-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] wide;
        wide = RW'(a);
        wide = wide + RND_HALF;
        return wide >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [RW-1:0] v);
        logic signed [RW-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[DATA_W-1:0];
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_tap = (tap_idx == AW'(NTAPS - 1));
    assign coef_we  = coef_wr && (state == IDLE) && (int'(coef_addr) < NTAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = MAC;
            MAC:     if (flush)     state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Clearing on any valid IDLE cycle is equivalent to clearing on accept.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                mac_clr  = in_valid;
            end
            MAC:     mac_en    = !flush;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // The flush cycle lets the last product land in the accumulator before rounding.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_idx <= '0;
            flush   <= 1'b0;
        end else if (state == MAC) begin
            if (flush) begin
                flush   <= 1'b0;
                tap_idx <= '0;
            end else if (last_tap) begin
                flush   <= 1'b1;
                tap_idx <= '0;
            end else begin
                tap_idx <= tap_idx + AW'(1);
            end
        end else begin
            tap_idx <= '0;
            flush   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) x_line[k] <= '0;
        end else if (accept) begin
            x_line[0] <= in_data;
            for (int k = 1; k < NTAPS; k++) x_line[k] <= x_line[k-1];
        end
    end

    // Identity filter out of reset: only h[0] is non-zero, scaled by the output shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k < NTAPS; k++) h_ram[k] <= '0;
            h_ram[0] <= H_ONE;
        end else if (coef_we) begin
            h_ram[coef_addr] <= coef_data;
        end
    end

    rx_mac_slice #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clr),
        .enable (mac_en),
        .x      (x_line[tap_idx]),
        .h      (h_ram[tap_idx]),
        .acc    (acc)
    );

    // p1: rounded and saturated output register, held through back-pressure
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (state == MAC && flush) begin
            out_data <= sat_data(round_acc(acc));
        end
    end

endmodule

// File: tb/tb_rx_fir_mac.sv
// Scoreboard bench for rx_fir_mac: stimulus pushes expected outputs, a monitor pops
// and compares on every output handshake.
module tb_rx_fir_mac;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               coef_wr;
    logic [6:0]         coef_addr;
    logic signed [15:0] coef_data;

    int exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rx_fir_mac dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0d expected none", int'(out_data));
            end else begin
                check("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        coef_wr   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got in_ready=0 expected 1 within 300 cycles");
        end
    endtask

    task automatic send(input int d);
        wait_idle();
        in_valid = 1'b1;
        in_data  = d[15:0];
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wcoef(input int a, input int v);
        coef_wr   = 1'b1;
        coef_addr = a[6:0];
        coef_data = v[15:0];
        @(posedge clk);
        #1 coef_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        in_data   = '0;
        coef_addr = '0;
        coef_data = '0;
        do_reset();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", int'(out_data), 0);

        // Impulse through identity filter, with latency measured in clock edges
        exp_q.push_back(1000);
        send(1000);
        t0 = cyc;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", cyc - t0, 66);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(0);
            send(0);
        end
        drain();

        // Ramp coefficients h[k]=16k, impulse 16384 reads them back in order
        do_reset();
        for (int k = 0; k < 65; k++) wcoef(k, k * 16);
        exp_q.push_back(0);
        send(16384);
        for (int i = 1; i <= 65; i++) begin
            exp_q.push_back((i <= 64) ? i * 16 : 0);
            send(0);
        end
        drain();

        // Extremes, rounding and saturation
        do_reset();
        exp_q.push_back(32767);  send(32767);
        exp_q.push_back(-32768); send(-32768);
        wait_idle();
        wcoef(0, 32767);
        exp_q.push_back(32767);  send(32767);
        exp_q.push_back(-32768); send(-32768);
        wait_idle();
        wcoef(0, 8192);
        exp_q.push_back(2);  send(3);
        exp_q.push_back(-1); send(-3);
        drain();

        // Back-pressure hold for 10 cycles
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(700);
        send(700);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", int'(out_data), 700);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("consumed", exp_q.size(), 0);
        check("post_consume_valid", out_valid, 0);
        check("post_consume_ready", in_ready, 1);

        // Reset aborts a pass at tap 30
        send(1234);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        exp_q.push_back(500);
        send(500);
        drain();

        // Coefficient writes: dropped mid-pass, honoured in IDLE, same-cycle with accept
        do_reset();
        exp_q.push_back(300);
        send(300);
        repeat (10) @(posedge clk);
        #1;
        wcoef(0, 0);
        exp_q.push_back(300);
        send(300);
        drain();
        wait_idle();
        wcoef(0, 0);
        exp_q.push_back(0);
        send(300);
        drain();
        wait_idle();
        coef_wr   = 1'b1;
        coef_addr = 7'd0;
        coef_data = 16'sd16384;
        exp_q.push_back(400);
        send(400);
        coef_wr = 1'b0;
        drain();

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
